prim_credit_tx: RTL and testbench
=================================

// Module: prim_credit_tx
// PURPOSE
//  Credit-based transmitter: the sending end of a link into a remote prim_fifo_sync of known depth.
//  Upstream is valid/ready. The downstream link is valid-only, with no backpressure.
//  A local credit counter mirrors the free slots in the remote FIFO, so the remote FIFO never overflows.
//  The remote side returns one credit per pop, as a single-cycle pulse on credit_i.
// PARAMETERS
//  Width   16  data width of the upstream and link data
//  Credits 4   remote FIFO depth = initial credit count; must be >= 1
//  OutReg  1   1: tx_valid_o/tx_data_o registered (1-cycle latency); 0: combinational pass-through
//  CntW    vbits(Credits+1)  localparam, width of the credit count
// PORTS
//  clk_i      in   1      clock
//  rst_ni     in   1      asynchronous reset, active low
//  clr_i      in   1      synchronous clear: restore credits, drop the in-flight beat, clear err
//  wvalid_i   in   1      upstream beat valid
//  wready_o   out  1      upstream ready (a credit is available)
//  wdata_i    in   Width  upstream data
//  tx_valid_o out  1      link beat; remote FIFO pushes unconditionally when this is high
//  tx_data_o  out  Width  link data; 0 when tx_valid_o=0
//  credit_i   in   1      one credit returned (remote pop), 1-cycle pulse
//  credits_o  out  CntW   current credit count
//  idle_o     out  1      all credits home and no beat in flight
//  err_o      out  1      sticky: credit returned while count == Credits
// BEHAVIOUR
//  Reset: cnt=Credits, tx_valid_o=0, tx_data_o=0, err_o=0.
//   under_rst flag is set in reset and clears on the 1st clock after release.
//   wready_o=0 while under_rst.
//  wready_o = (cnt != 0) & ~under_rst & ~clr_i.
//   A credit_i arriving in the same cycle is NOT bypassed into wready_o.
//  send = wvalid_i & wready_o.
//  cnt_next = cnt - send + credit_i. Simultaneous send+credit_i leaves cnt unchanged, including at cnt=0 or cnt=Credits.
//  Overflow: credit_i & ~send & cnt==Credits -> cnt holds at Credits, err_o<=1 (sticky until clr_i or reset).
//  Underflow: impossible by construction (send requires cnt!=0).
//  OutReg=1: tx_valid_o<=send, tx_data_o<=send?wdata_i:0. Exactly one cycle after the handshake; back-to-back beats every cycle.
//  OutReg=0: tx_valid_o=send, tx_data_o=send?wdata_i:0, same cycle.
//  clr_i has priority over everything: cnt<=Credits, err<=0, registered tx_valid_o<=0.
//   credit_i in a clr cycle is ignored.
//   The remote FIFO is expected to be cleared in the same cycle.
//  idle_o = (cnt==Credits) & ~tx_valid_o.
//  credits_o = cnt, the registered value.
//  Mid-operation reset: all state returns to reset values asynchronously; any beat in flight is lost.
// STRUCTURE
//  Sub-module prim_credit_cnt (Credits, CntW): holds the counter, saturation and err logic.
//   Inputs: clr_i, dec_i, inc_i. Outputs: cnt_o, err_o.
//  Top level holds: under_rst, the handshake, and the output register (generate on OutReg).
//  Width helpers come from prim_util_pkg::vbits. No new package types are required.
//  Assertions:
//   - tx_valid_o |-> !$isunknown(tx_data_o)
//   - cnt <= Credits
//   - send |-> cnt != 0
// TESTING (Credits=4, Width=16, OutReg=1 unless noted)
//  1 Reset release, wvalid_i=1 held -> wready_o=0 in 1st cycle, 1 in 2nd; credits_o=4 at reset.
//  2 Send 4 beats 0xA0..0xA3, no credits returned ->
//     tx_valid_o pulses 4 cycles, each 1 cycle after its handshake;
//     credits_o = 3,2,1,0; wready_o=0 after the 4th beat; 5th beat stalls.
//  3 At cnt=0, credit_i=1 with wvalid_i=1 -> no send that cycle; cnt=1; send next cycle; cnt back to 0.
//  4 At cnt=2, send and credit_i in the same cycle -> cnt stays 2; tx_data_o shows the beat next cycle.
//  5 At cnt=4, credit_i=1 -> cnt stays 4, err_o=1 sticky; clr_i -> err_o=0, cnt=4, tx_valid_o=0, idle_o=1.
//  6 OutReg=0: handshake with wdata_i=0x5A5A -> same-cycle tx_valid_o=1, tx_data_o=0x5A5A.
//     Reset asserted mid-stream -> tx_valid_o=0, credits_o=4 immediately.

Source files
------------

// File: rtl/prim_util_pkg.sv
// ============================================================================
// Module  : prim_util_pkg
// Brief   : Shared width helpers for the prim_* blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prim_util_pkg;

   // Bits needed to index 'value' distinct states; never returns 0.
   function automatic integer vbits(input integer value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

`default_nettype wire

// File: rtl/prim_credit_cnt.sv
// ============================================================================
// Module  : prim_credit_cnt
// Brief   : Saturating credit counter with sticky overflow error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_credit_cnt #(
   parameter int Credits = 4,
   parameter int CntW    = 3
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            dec_i,
   input  logic            inc_i,
   output logic [CntW-1:0] cnt_o,
   output logic            err_o
);

   localparam logic [CntW-1:0] CreditsW = CntW'(Credits);

   logic [CntW-1:0] r_cnt;
   logic            r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= CreditsW;
         r_err <= 1'b0;
      end else if (clr_i) begin
         r_cnt <= CreditsW;
         r_err <= 1'b0;
      end else if (inc_i && !dec_i) begin
         // A return with every credit already home is a remote-side protocol error.
         if (r_cnt == CreditsW) begin
            r_err <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CntW'(1);
         end
      end else if (dec_i && !inc_i) begin
         r_cnt <= r_cnt - CntW'(1);
      end
   end

   assign cnt_o = r_cnt;
   assign err_o = r_err;

`ifndef SYNTHESIS
   a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) r_cnt <= CreditsW);
`endif

endmodule

`default_nettype wire

// File: rtl/prim_credit_tx.sv
// ============================================================================
// Module  : prim_credit_tx
// Brief   : Credit-based transmitter feeding a remote FIFO over a valid-only link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_credit_tx
   import prim_util_pkg::*;
#(
   parameter int   Width   = 16,
   parameter int   Credits = 4,
   parameter bit   OutReg  = 1'b1,
   localparam int  CntW    = vbits(Credits + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             tx_valid_o,
   output logic [Width-1:0] tx_data_o,
   input  logic             credit_i,
   output logic [CntW-1:0]  credits_o,
   output logic             idle_o,
   output logic             err_o
);

   localparam logic [CntW-1:0] CreditsW = CntW'(Credits);

   logic            r_under_rst;
   logic            w_wready;
   logic            w_send;
   logic [CntW-1:0] w_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_under_rst <= 1'b1;
      end else begin
         r_under_rst <= 1'b0;
      end
   end

   // Credits returned this cycle are not bypassed; they become usable next cycle.
   assign w_wready = (w_cnt != '0) && !r_under_rst && !clr_i;
   assign w_send   = wvalid_i && w_wready;
   assign wready_o = w_wready;

   prim_credit_cnt #(
      .Credits (Credits),
      .CntW    (CntW)
   ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .dec_i  (w_send),
      .inc_i  (credit_i),
      .cnt_o  (w_cnt),
      .err_o  (err_o)
   );

   generate
      if (OutReg) begin : g_outreg
         logic             r_tx_valid;
         logic [Width-1:0] r_tx_data;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_tx_valid <= 1'b0;
               r_tx_data  <= '0;
            end else if (clr_i) begin
               r_tx_valid <= 1'b0;
               r_tx_data  <= '0;
            end else begin
               r_tx_valid <= w_send;
               r_tx_data  <= w_send ? wdata_i : '0;
            end
         end

         assign tx_valid_o = r_tx_valid;
         assign tx_data_o  = r_tx_data;
      end else begin : g_passthru
         assign tx_valid_o = w_send;
         assign tx_data_o  = w_send ? wdata_i : '0;
      end
   endgenerate

   assign credits_o = w_cnt;
   assign idle_o    = (w_cnt == CreditsW) && !tx_valid_o;

`ifndef SYNTHESIS
   a_data_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tx_valid_o |-> !$isunknown(tx_data_o));
   a_send_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_send |-> (w_cnt != '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_prim_credit_tx.sv
// ============================================================================
// Module  : tb_prim_credit_tx
// Brief   : Scoreboard bench for prim_credit_tx (OutReg=1 and OutReg=0 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prim_credit_tx;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, clr, wvalid, credit;
   logic [15:0] wdata;
   logic        wready, txv, idle, err;
   logic [15:0] txd;
   logic [2:0]  credits;

   logic        rst0_n, wvalid0;
   logic [15:0] wdata0;
   logic        wready0, txv0, idle0, err0;
   logic [15:0] txd0;
   logic [2:0]  credits0;

   prim_credit_tx #(.Width(16), .Credits(4), .OutReg(1'b1)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
      .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
      .tx_valid_o(txv), .tx_data_o(txd), .credit_i(credit),
      .credits_o(credits), .idle_o(idle), .err_o(err)
   );

   prim_credit_tx #(.Width(16), .Credits(4), .OutReg(1'b0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst0_n), .clr_i(1'b0),
      .wvalid_i(wvalid0), .wready_o(wready0), .wdata_i(wdata0),
      .tx_valid_o(txv0), .tx_data_o(txd0), .credit_i(1'b0),
      .credits_o(credits0), .idle_o(idle0), .err_o(err0)
   );

   int          n_tot = 0;
   int          n_bad = 0;
   int          m_cnt;
   bit          m_err;
   bit          m_ur;
   logic [15:0] q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Called at a negedge; drives one cycle, scores the outputs after the posedge.
   task automatic cycle(input bit v, input logic [15:0] d, input bit cr, input bit cl);
      bit          exp_rdy;
      bit          send;
      bit          exp_v;
      logic [15:0] exp_d;
      wvalid = v; wdata = d; credit = cr; clr = cl;
      #1;
      exp_rdy = (m_cnt != 0) && !m_ur && !cl;
      check("wready", {31'd0, wready}, {31'd0, exp_rdy});
      send = v && exp_rdy;
      if (send) q.push_back(d);
      @(posedge clk);
      m_ur = 1'b0;
      if (cl) begin
         m_cnt = 4;
         m_err = 1'b0;
      end else if (cr && !send && m_cnt == 4) begin
         m_err = 1'b1;
      end else begin
         m_cnt = m_cnt - int'(send) + int'(cr);
      end
      #1;
      exp_v = (q.size() > 0);
      exp_d = exp_v ? q.pop_front() : 16'h0;
      check("tx_valid", {31'd0, txv}, {31'd0, exp_v});
      check("tx_data", {16'd0, txd}, {16'd0, exp_d});
      check("credits", {29'd0, credits}, 32'(m_cnt));
      check("err", {31'd0, err}, {31'd0, m_err});
      check("idle", {31'd0, idle}, {31'd0, (m_cnt == 4) && !exp_v});
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; rst0_n = 1'b0;
      clr = 1'b0; wvalid = 1'b1; wdata = 16'h0; credit = 1'b0;
      wvalid0 = 1'b0; wdata0 = 16'h0;
      m_cnt = 4; m_err = 1'b0; m_ur = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_credits", {29'd0, credits}, 32'd4);
      check("rst_tx_valid", {31'd0, txv}, 32'd0);
      check("rst_tx_data", {16'd0, txd}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_wready", {31'd0, wready}, 32'd0);
      rst_n = 1'b1; rst0_n = 1'b1;

      // Reset release: first cycle stalls, then four beats drain the credits.
      cycle(1'b1, 16'h00A0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'h00A0 + 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'h00A4, 1'b0, 1'b0);

      // Credit at zero is not bypassed; the beat goes out one cycle later.
      cycle(1'b1, 16'h00A4, 1'b1, 1'b0);
      cycle(1'b1, 16'h00A4, 1'b0, 1'b0);

      // Reach two credits, then send and return together.
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      cycle(1'b1, 16'h00B1, 1'b1, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);

      // Overflow sets a sticky error; clear restores everything.
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      cycle(1'b1, 16'h00C1, 1'b0, 1'b0);
      cycle(1'b1, 16'h00C2, 1'b1, 1'b1);
      cycle(1'b0, 16'h0, 1'b0, 1'b0);

      // Randomised traffic with legal credit returns and occasional clears.
      for (int i = 0; i < 60; i++) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom),
               (m_cnt < 4) && ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 24) == 0));
      end
      cycle(1'b0, 16'h0, 1'b0, 1'b0);

      // Pass-through instance: same-cycle beat, then asynchronous reset mid-stream.
      wvalid0 = 1'b1; wdata0 = 16'h5A5A;
      #1;
      check("pt_wready", {31'd0, wready0}, 32'd1);
      check("pt_tx_valid", {31'd0, txv0}, 32'd1);
      check("pt_tx_data", {16'd0, txd0}, 32'h5A5A);
      @(posedge clk); #1;
      check("pt_credits", {29'd0, credits0}, 32'd3);
      @(negedge clk);
      wdata0 = 16'h1234;
      #1;
      check("pt_tx_data2", {16'd0, txd0}, 32'h1234);
      rst0_n = 1'b0;
      #1;
      check("pt_rst_tx_valid", {31'd0, txv0}, 32'd0);
      check("pt_rst_tx_data", {16'd0, txd0}, 32'd0);
      check("pt_rst_credits", {29'd0, credits0}, 32'd4);
      check("pt_rst_idle", {31'd0, idle0}, 32'd1);
      check("pt_rst_err", {31'd0, err0}, 32'd0);
      wvalid0 = 1'b0;
      @(negedge clk);
      rst0_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
